// File: rtl/sync_clk_div_n_if.sv
// sync_clk_div_n_if: control and status bundle of the programmable clock divider.
interface sync_clk_div_n_if #(parameter int WIDTH = 8) ();
    logic             en;
    logic [WIDTH-1:0] div_val;
    logic             div_load;
    logic             odd_hi;
    logic             out_clk;
    logic             tick;
    logic             pend;
    logic [WIDTH-1:0] cur_div;
    modport master (output en, div_val, div_load, odd_hi, input out_clk, tick, pend, cur_div);
    modport slave  (input en, div_val, div_load, odd_hi, output out_clk, tick, pend, cur_div);
endinterface

// File: rtl/sync_clk_div_n.sv
// sync_clk_div_n: run-time programmable integer clock divider with registered out_clk/tick.
module sync_clk_div_n #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input logic              clk,
    input logic              rst,
    sync_clk_div_n_if.slave  bus
);
    localparam logic [WIDTH-1:0] DEF_DIV = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d, cur_div_q, cur_div_d, shadow_q, shadow_d, hi_q, hi_d, new_div, raw_div;
    logic             out_clk_q, out_clk_d, tick_q, tick_d, pend_q, pend_d, run_q, run_d, start;

    always_comb begin
        raw_div   = bus.div_load ? bus.div_val : shadow_q;
        new_div   = (raw_div < WIDTH'(2)) ? WIDTH'(2) : raw_div;
        start     = ~run_q | (cnt_q == cur_div_q - WIDTH'(1));
        cnt_d     = '0;
        out_clk_d = 1'b0;
        tick_d    = 1'b0;
        run_d     = bus.en;
        pend_d    = pend_q;
        shadow_d  = bus.div_load ? bus.div_val : shadow_q;
        cur_div_d = cur_div_q;
        hi_d      = hi_q;
        // Idle edges and period-start edges are the only places the divisor may change.
        if (!bus.en || start) begin
            cur_div_d = (bus.div_load | pend_q) ? new_div : cur_div_q;
            pend_d    = 1'b0;
        end
        if (bus.en && start) begin
            hi_d      = (cur_div_d >> 1) + {{(WIDTH-1){1'b0}}, cur_div_d[0] & bus.odd_hi};
            out_clk_d = 1'b1;
            tick_d    = 1'b1;
        end else if (bus.en) begin
            cnt_d     = cnt_q + WIDTH'(1);
            out_clk_d = cnt_d < hi_q;
            pend_d    = pend_q | bus.div_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            out_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            pend_q    <= 1'b0;
            run_q     <= 1'b0;
            cur_div_q <= DEF_DIV;
            shadow_q  <= '0;
            hi_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            out_clk_q <= out_clk_d;
            tick_q    <= tick_d;
            pend_q    <= pend_d;
            run_q     <= run_d;
            cur_div_q <= cur_div_d;
            shadow_q  <= shadow_d;
            hi_q      <= hi_d;
        end
    end

    assign bus.out_clk = out_clk_q;
    assign bus.tick    = tick_q;
    assign bus.pend    = pend_q;
    assign bus.cur_div = cur_div_q;
endmodule

// File: doc/sync_clk_div_n.md
# sync_clk_div_n

Parametrised, fully synchronous integer clock divider generating a flop-driven divided clock of any ratio from 2 to 2^WIDTH−1. It selects odd-ratio duty, changes ratio glitch-free at period boundaries and produces a one-cycle period-start tick. It is the run-time-programmable successor to the fixed ÷2/÷8 ripple dividers. All outputs are registered on the single input clock, so it sits directly in the clk domain without ripple skew.

## Interface
- WIDTH, 8, width of divisor and internal counter
- DEFAULT_DIV, 8, divisor after reset; values below 2 treated as 2
- clk  input  1  source clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  run enable; 0 holds divider idle
- div_val  input  WIDTH  requested divisor D
- div_load  input  1  one-cycle strobe capturing div_val
- odd_hi  input  1  odd-D duty select: 1 = high phase longer, 0 = low phase longer
- out_clk  output  1  divided clock, flop output
- tick  output  1  one-cycle pulse in first cycle of each out_clk period
- pend  output  1  captured divisor waiting for next period boundary
- cur_div  output  WIDTH  divisor currently in effect

## Operation
- Effective divisor: cur_div = max(D, 2); div_val of 0 or 1 clamps to 2.
- High length H: even D gives H = D/2. Odd D gives H = (D+1)/2 if odd_hi, else (D−1)/2.
- Period: out_clk high for H clk cycles, then low for D−H cycles, repeating. Phase counter cnt runs 0..D−1 and wraps to 0.
- out_clk and tick are flops whose next values decode from next cnt. No combinational path from cnt to outputs.
- tick = 1 exactly in the cycle where cnt = 0 while running.
- Reset (any time, including mid-period) at next edge: cnt=0, out_clk=0, tick=0, pend=0, cur_div=clamp(DEFAULT_DIV), shadow=0.
- Idle (en=0 at an edge): cnt←0, out_clk←0, tick←0. A pending load applies at that edge; cur_div updates.
- Start: first edge with en=1 after idle begins a period. out_clk=1, tick=1, cnt=0 in the following cycle.
- en deasserted mid-period aborts the period. The next cycle is out_clk=0, with no partial-phase completion.
- Divisor load:
  - div_load=1 at an edge captures div_val into the shadow register and sets pend.
  - The shadow becomes cur_div at the next period-start edge (the edge producing cnt=0) and pend clears there.
  - Repeated loads before the boundary overwrite the shadow; the last one wins.
  - A load at the same edge as a period start applies immediately to that new period, with no pend cycle.
- odd_hi is sampled at every period-start edge. Mid-period changes never alter the current period.
- cur_div never changes mid-period, so no runt high or low pulse exists on out_clk.

## Timing
- Latency from en rise (sampled) to out_clk=1: 1 clk.
- Load-to-effect latency: from 1 clk (capture at the boundary edge) up to D_old clks.
- Steady-state out_clk frequency = f_clk / cur_div.
- For even D, duty is exactly 50%. For odd D, duty is H/D.
- Rising edges of out_clk are aligned with tick and coincide with clk edges (one flop delay).

## Test plan
- Reset then en=1, DEFAULT_DIV=8 -> out_clk 4 high/4 low, tick every 8 clks, cur_div=8, pend=0.
- div_val=5 loaded mid-period -> pend=1 until the boundary, then periods of 5. With odd_hi=1: 3 high/2 low. Toggle odd_hi=0 mid-period -> the following period is 2 high/3 low.
- div_val=0 and div_val=1 -> cur_div=2, out_clk alternates every clk, tick every 2 clks.
- Two loads (6 then 3) within one ÷8 period -> the ÷8 period completes intact, then ÷3 applies and ÷6 is never seen.
- Load coincident with the period-start edge -> new D governs that period immediately, pend never asserts.
- rst asserted mid-high-phase, and separately en dropped mid-phase -> next cycle out_clk=0, tick=0. Restart shows a full first period with tick=1.
